// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI slave, CPOL=0 / CPHA=1, MSB first, oversampled by the system clock.
// SPI_CLK, SPI_EN and SPI_MOSI are synchronised into the clk domain and SCK
// edges are detected from the synchronised clock. One-byte transmit buffer
// feeds the TX shift register at every byte start; received bytes are
// presented on rx_data with a single-cycle rx_valid pulse.
//
// Optional feature: define SPI_SLAVE_UNDERRUN_EN to build the sticky
// tx_underrun flag; otherwise tx_underrun is tied to 0.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth (>= 2) on SPI_CLK, SPI_EN, SPI_MOSI
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   SPI_CLK      serial clock from master (idles low, <= clk/8)
//   SPI_EN       active-high select, frames one or more bytes
//   SPI_MOSI     serial data from master
//   SPI_MISO     serial data to master
//   tx_data      next byte to send
//   tx_load      write strobe for tx_data (accepted only when tx_ready)
//   tx_ready     transmit buffer empty
//   rx_data      last complete received byte
//   rx_valid     one-cycle pulse when rx_data updates
//   tx_underrun  sticky: a byte started with nothing buffered
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SPI_CLK,
    input  logic       SPI_EN,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // Input synchronisers
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] en_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sck_sync_reg[gi]  <= 1'b0;
                        en_sync_reg[gi]   <= 1'b0;
                        mosi_sync_reg[gi] <= 1'b0;
                    end else begin
                        sck_sync_reg[gi]  <= SPI_CLK;
                        en_sync_reg[gi]   <= SPI_EN;
                        mosi_sync_reg[gi] <= SPI_MOSI;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sck_sync_reg[gi]  <= 1'b0;
                        en_sync_reg[gi]   <= 1'b0;
                        mosi_sync_reg[gi] <= 1'b0;
                    end else begin
                        sck_sync_reg[gi]  <= sck_sync_reg[gi-1];
                        en_sync_reg[gi]   <= en_sync_reg[gi-1];
                        mosi_sync_reg[gi] <= mosi_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic sck_s;
    logic en_s;
    logic mosi_s;
    logic sck_last_reg;

    assign sck_s  = sck_sync_reg[SYNC_STAGES-1];
    assign en_s   = en_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    // One extra flop behind the synchroniser so both edge-detect samples
    // are fully synchronised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_last_reg <= 1'b0;
        end else begin
            sck_last_reg <= sck_s;
        end
    end

    logic sck_rise;
    logic sck_fall;
    assign sck_rise = sck_s & ~sck_last_reg;
    assign sck_fall = ~sck_s & sck_last_reg;

    // ---------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en_s)  state_next = ACTIVE;
            ACTIVE:  if (!en_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic       miso_reg;
    logic       buf_full_reg;

    always_comb begin
        SPI_MISO = 1'b0;
        tx_ready = ~buf_full_reg;
        if (state_reg == ACTIVE) begin
            SPI_MISO = miso_reg;
        end
    end

    // ---------------------------------------------------------------------
    // Control strobes
    // ---------------------------------------------------------------------
    logic [2:0] bit_cnt_reg;
    logic       edge_en;      // SCK edges count only while selected
    logic       byte_done;    // 8th falling edge of a byte
    logic       byte_start;   // TX shift register reload point
    logic       abort;        // select dropped: leave ACTIVE
    logic       load_accept;

    assign edge_en     = (state_reg == ACTIVE) && en_s;
    assign byte_done   = edge_en && sck_fall && (bit_cnt_reg == 3'd7);
    assign byte_start  = ((state_reg == IDLE) && en_s) || byte_done;
    assign abort       = (state_reg == ACTIVE) && !en_s;
    assign load_accept = tx_load && !buf_full_reg;

    // ---------------------------------------------------------------------
    // Transmit buffer
    // A byte start takes priority over a same-cycle load: the load lands in
    // the now-free buffer only if the buffer was empty at the start.
    // ---------------------------------------------------------------------
    logic [7:0] buf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_reg      <= 8'h00;
            buf_full_reg <= 1'b0;
        end else if (byte_start && buf_full_reg) begin
            buf_full_reg <= 1'b0;
        end else if (load_accept) begin
            buf_reg      <= tx_data;
            buf_full_reg <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Shift datapath
    // ---------------------------------------------------------------------
    logic [7:0] tx_shift_reg;
    logic [7:0] rx_shift_reg;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_reg <= 8'h00;
            rx_shift_reg <= 8'h00;
            bit_cnt_reg  <= 3'd0;
            miso_reg     <= 1'b0;
            rx_data_reg  <= 8'h00;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            if (abort) begin
                // Partial byte is discarded; any consumed TX byte is lost.
                tx_shift_reg <= 8'h00;
                rx_shift_reg <= 8'h00;
                bit_cnt_reg  <= 3'd0;
                miso_reg     <= 1'b0;
            end else begin
                if (byte_start) begin
                    tx_shift_reg <= buf_full_reg ? buf_reg : 8'h00;
                end else if (edge_en && sck_rise) begin
                    miso_reg     <= tx_shift_reg[7];
                    tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                end
                if (edge_en && sck_fall) begin
                    rx_shift_reg <= {rx_shift_reg[6:0], mosi_s};
                    bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                end
                if (byte_done) begin
                    rx_data_reg  <= {rx_shift_reg[6:0], mosi_s};
                    rx_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;

    // ---------------------------------------------------------------------
    // Optional underrun flag
    // An accepted load clears the flag even when it coincides with an empty
    // byte start, since the buffer holds data again afterwards.
    // ---------------------------------------------------------------------
`ifdef SPI_SLAVE_UNDERRUN_EN
    logic underrun_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_reg <= 1'b0;
        end else if (load_accept) begin
            underrun_reg <= 1'b0;
        end else if (byte_start && !buf_full_reg) begin
            underrun_reg <= 1'b1;
        end
    end

    assign tx_underrun = underrun_reg;
`else
    assign tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Randomised bench for spi_slave. A bit-banged SPI master (SCK = clk/8)
// drives frames; a transaction-level model (a one-entry TX buffer queue and
// an underrun flag) predicts the bytes the master should receive and the
// bytes the slave should report. Expected rx bytes are queued when a byte is
// issued and a separate monitor pops them on every rx_valid.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int SYNC = 2;
    localparam int HALF = 4;   // clk cycles per SCK half period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SPI_CLK = 1'b0;
    logic       SPI_EN = 1'b0;
    logic       SPI_MOSI = 1'b0;
    logic       SPI_MISO;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;

    spi_slave #(.SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SPI_CLK     (SPI_CLK),
        .SPI_EN      (SPI_EN),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_exp_q[$];    // bytes the slave must report, in order
    logic [7:0] miso_exp_q[$];  // bytes the master must receive, in order
    logic [7:0] mdl_buf_q[$];   // transmit buffer, at most one entry
    bit         mdl_underrun = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end else begin
            $display("ok   %s: %02h", name, act);
        end
    endtask

    function automatic logic [7:0] exp_underrun();
`ifdef SPI_SLAVE_UNDERRUN_EN
        return {7'd0, mdl_underrun};
`else
        return 8'h00;
`endif
    endfunction

    // Model: a load is kept only if the buffer is empty.
    task automatic mdl_load(input logic [7:0] v);
        if (mdl_buf_q.size() == 0) begin
            mdl_buf_q.push_back(v);
            mdl_underrun = 1'b0;
        end
    endtask

    // Model: a byte start sends the buffered byte, or zero when empty.
    task automatic mdl_byte_start();
        if (mdl_buf_q.size() != 0) begin
            miso_exp_q.push_back(mdl_buf_q.pop_front());
        end else begin
            miso_exp_q.push_back(8'h00);
            mdl_underrun = 1'b1;
        end
    endtask

    task automatic drive_load(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        mdl_load(v);
        check("tx_ready_after_load", {7'd0, tx_ready}, (mdl_buf_q.size() == 0) ? 8'h01 : 8'h00);
    endtask

    // One SPI_EN frame of n bytes. abort_bits != 0 drops SPI_EN after that
    // many SCK cycles. coinc places a tx_load on the first byte-start cycle.
    task automatic frame(input int n, input logic [7:0] mb [4], input int abort_bits,
                         input bit coinc, input logic [7:0] cv);
        logic [7:0] got;
        int         bits_done;
        bit         stop;
        bit         cut;
        @(negedge clk);
        SPI_EN = 1'b1;
        mdl_byte_start();
        if (coinc) begin
            repeat (SYNC) @(negedge clk);
            tx_data = cv;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            mdl_load(cv);
            repeat (5) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        bits_done = 0;
        stop = 1'b0;
        for (int b = 0; b < n && !stop; b++) begin
            cut = (abort_bits != 0) && (abort_bits < (b + 1) * 8);
            if (b > 0) mdl_byte_start();
            if (!cut) rx_exp_q.push_back(mb[b]);
            got = 8'h00;
            for (int i = 7; i >= 0 && !stop; i--) begin
                SPI_MOSI = mb[b][i];
                SPI_CLK = 1'b1;
                repeat (HALF) @(negedge clk);
                got = {got[6:0], SPI_MISO};
                SPI_CLK = 1'b0;
                repeat (HALF) @(negedge clk);
                bits_done++;
                if (abort_bits != 0 && bits_done == abort_bits) stop = 1'b1;
            end
            if (!cut) check("miso_byte", got, miso_exp_q.pop_front());
            else void'(miso_exp_q.pop_front());
        end
        SPI_EN = 1'b0;
        SPI_MOSI = 1'b0;
        repeat (SYNC + 4) @(negedge clk);
        check("miso_idle", {7'd0, SPI_MISO}, 8'h00);
        check("tx_underrun", {7'd0, tx_underrun}, exp_underrun());
    endtask

    // Scoreboard monitor for the receive side.
    logic rx_valid_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            check("rx_valid_width", {7'd0, rx_valid_prev}, 8'h00);
            if (rx_exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_unexpected: got %02h expected none", rx_data);
            end else begin
                check("rx_data", rx_data, rx_exp_q.pop_front());
            end
        end
        rx_valid_prev = rx_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] mb [4];
        int n;
        int ab;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_miso", {7'd0, SPI_MISO}, 8'h00);
        check("rst_tx_ready", {7'd0, tx_ready}, 8'h01);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("rst_underrun", {7'd0, tx_underrun}, 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte with preload
        drive_load(8'hA5);
        mb[0] = 8'h3C;
        frame(1, mb, 0, 1'b0, 8'h00);
        check("tx_ready_after_frame", {7'd0, tx_ready}, 8'h01);

        // Two bytes, only the first preloaded
        drive_load(8'h5A);
        mb[0] = 8'h01; mb[1] = 8'h80;
        frame(2, mb, 0, 1'b0, 8'h00);

        // Abort after 4 SCK cycles, then a full 0xFF byte
        mb[0] = 8'hAA;
        frame(1, mb, 4, 1'b0, 8'h00);
        drive_load(8'h5C);
        mb[0] = 8'hFF;
        frame(1, mb, 0, 1'b0, 8'h00);

        // Second load while buffer full is ignored
        drive_load(8'h11);
        drive_load(8'h22);
        mb[0] = 8'h96;
        frame(1, mb, 0, 1'b0, 8'h00);

        // Load coincident with byte start on empty buffer
        mb[0] = 8'h12; mb[1] = 8'h34;
        frame(2, mb, 0, 1'b1, 8'h77);

        // Reset in the middle of a byte
        drive_load(8'hFF);
        @(negedge clk);
        SPI_EN = 1'b1;
        mdl_byte_start();
        repeat (8) @(negedge clk);
        drive_load(8'h99);
        for (int i = 0; i < 3; i++) begin
            SPI_MOSI = 1'b1;
            SPI_CLK = 1'b1;
            repeat (HALF) @(negedge clk);
            SPI_CLK = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        SPI_CLK = 1'b1;
        repeat (HALF) @(negedge clk);
        check("pre_rst_miso", {7'd0, SPI_MISO}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("midrst_miso", {7'd0, SPI_MISO}, 8'h00);
        check("midrst_tx_ready", {7'd0, tx_ready}, 8'h01);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("midrst_underrun", {7'd0, tx_underrun}, 8'h00);
        mdl_buf_q.delete();
        miso_exp_q.delete();
        mdl_underrun = 1'b0;
        SPI_CLK = 1'b0;
        SPI_EN = 1'b0;
        SPI_MOSI = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        drive_load(8'h3E);
        mb[0] = 8'hC3;
        frame(1, mb, 0, 1'b0, 8'h00);

        // Randomised frames
        for (int it = 0; it < 15; it++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) mb[k] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) drive_load(8'($urandom));
            if ($urandom_range(0, 3) == 0) drive_load(8'($urandom));
            ab = 0;
            if ($urandom_range(0, 4) == 0) begin
                ab = $urandom_range(1, n * 8 - 1);
                if (ab % 8 == 0) ab = ab + 1;
            end
            frame(n, mb, ab, 1'b0, 8'h00);
        end

        repeat (20) @(negedge clk);
        check("rx_queue_drained", 8'(rx_exp_q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
